// File: rtl/qspi_rom_reader.sv
// qspi_rom_reader
// Reads single bytes from a quad-SPI NOR flash with the fast-read-quad-I/O
// command and streams sequential addresses without re-issuing the command.
//
// Ports:
//   clk, reset           single clock, synchronous active-high reset
//   addr, rd_req         byte read request (accepted while busy = 0)
//   restart              abort any transaction, return to idle
//   busy                 transaction in flight
//   data, data_valid     returned byte and its one-cycle strobe
//   sclk, select         flash clock (clk/2) and active-low chip select
//   io_out, io_oe        nibble driven to flash and per-line enables
//   io_in                nibble returned by flash
module qspi_rom_reader #(
  parameter logic [7:0]  CMD          = 8'hEB,
  parameter logic [7:0]  MODE         = 8'hFF,
  parameter int unsigned DUMMY_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] addr,
  input  logic        rd_req,
  input  logic        restart,
  output logic        busy,
  output logic [7:0]  data,
  output logic        data_valid,
  output logic        sclk,
  output logic        select,
  output logic [3:0]  io_out,
  output logic [3:0]  io_oe,
  input  logic [3:0]  io_in
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA, S_STREAM, S_GAP
  } state_t;

  state_t      state, n_state;
  logic        phase, n_phase;
  logic [4:0]  cnt, n_cnt;
  logic [23:0] addr_q, n_addr;
  logic [3:0]  hi_q, n_hi;
  logic [7:0]  n_data;
  logic        n_valid, n_busy, n_sclk, n_select;
  logic [3:0]  n_io_out, n_io_oe;

  // Index of the final sclk period in each serial state.
  function automatic logic [4:0] last_cnt(input state_t s);
    case (s)
      S_CMD:   return 5'd7;
      S_ADDR:  return 5'd5;
      S_DUMMY: return 5'(DUMMY_CYCLES - 1);
      default: return 5'd1;
    endcase
  endfunction

  function automatic state_t succ(input state_t s);
    case (s)
      S_CMD:   return S_ADDR;
      S_ADDR:  return S_MODE;
      S_MODE:  return (DUMMY_CYCLES == 0) ? S_DATA : S_DUMMY;
      S_DUMMY: return S_DATA;
      default: return S_STREAM;
    endcase
  endfunction

  // Next-state logic; every output is then registered from the next state so
  // pins change only on the phase-0 boundary.
  always_comb begin
    n_state = state;
    n_phase = phase;
    n_cnt   = cnt;
    n_addr  = addr_q;
    n_hi    = hi_q;
    n_data  = data;
    n_valid = 1'b0;
    n_busy  = busy;
    if (restart) begin
      n_state = S_IDLE;
      n_phase = 1'b0;
      n_cnt   = '0;
      n_busy  = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rd_req) begin
            n_addr  = addr;
            n_state = S_CMD;
            n_cnt   = '0;
            n_phase = 1'b0;
            n_busy  = 1'b1;
          end
        end
        S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA: begin
          if (!phase) begin
            n_phase = 1'b1;
          end else begin
            n_phase = 1'b0;
            if (state == S_DATA) begin
              if (cnt == 5'd0) n_hi = io_in;
              else             n_data = {hi_q, io_in};
            end
            if (cnt == last_cnt(state)) begin
              n_cnt   = '0;
              n_state = succ(state);
              if (state == S_DATA) begin
                n_valid = 1'b1;
                n_busy  = 1'b0;
              end
            end else begin
              n_cnt = cnt + 5'd1;
            end
          end
        end
        S_STREAM: begin
          if (rd_req) begin
            n_addr  = addr;
            n_busy  = 1'b1;
            n_cnt   = '0;
            n_phase = 1'b0;
            n_state = (addr == addr_q + 24'd1) ? S_DATA : S_GAP;
          end
        end
        S_GAP: begin
          if (cnt == 5'd1) begin
            n_cnt   = '0;
            n_state = S_CMD;
          end else begin
            n_cnt = cnt + 5'd1;
          end
        end
        default: n_state = S_IDLE;
      endcase
    end

    n_select = !(n_state inside {S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA, S_STREAM});
    n_sclk   = n_phase && (n_state inside {S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA});
    n_io_out = '0;
    n_io_oe  = '0;
    case (n_state)
      S_CMD: begin
        n_io_oe  = 4'b0001;
        n_io_out = {3'b000, CMD[3'(7 - n_cnt)]};
      end
      S_ADDR: begin
        n_io_oe = 4'hF;
        case (n_cnt[2:0])
          3'd0:    n_io_out = n_addr[23:20];
          3'd1:    n_io_out = n_addr[19:16];
          3'd2:    n_io_out = n_addr[15:12];
          3'd3:    n_io_out = n_addr[11:8];
          3'd4:    n_io_out = n_addr[7:4];
          default: n_io_out = n_addr[3:0];
        endcase
      end
      S_MODE: begin
        n_io_oe  = 4'hF;
        n_io_out = (n_cnt == 5'd0) ? MODE[7:4] : MODE[3:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      phase      <= 1'b0;
      cnt        <= '0;
      addr_q     <= '0;
      hi_q       <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      sclk       <= 1'b0;
      select     <= 1'b1;
      io_out     <= '0;
      io_oe      <= '0;
    end else begin
      state      <= n_state;
      phase      <= n_phase;
      cnt        <= n_cnt;
      addr_q     <= n_addr;
      hi_q       <= n_hi;
      data       <= n_data;
      data_valid <= n_valid;
      busy       <= n_busy;
      sclk       <= n_sclk;
      select     <= n_select;
      io_out     <= n_io_out;
      io_oe      <= n_io_oe;
    end
  end

endmodule

// File: doc/qspi_rom_reader.md
# qspi_rom_reader

Bridge between the console core's cartridge read port and an external quad-SPI NOR flash holding the ROM image. Accepts single-byte read requests, issues fast-read-quad-I/O (0xEB) transactions on the four shared uio lines, and returns each byte with a valid strobe. Sequential addresses are streamed without re-issuing command or address. Its flash-side pins drive the bench `qspi_rom_emu` directly.

## Interface
Parameters:
- `CMD`, 8'hEB: read command, sent serially on IO0, MSB first.
- `MODE`, 8'hFF: mode byte sent after address; 0xFF means no continuous-read mode.
- `DUMMY_CYCLES`, 4: sclk cycles with IO lines released before data.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `addr`  in  24  byte address; sampled with an accepted `rd_req`.
- `rd_req`  in  1  read request; accepted only when `busy`=0.
- `restart`  in  1  abort any transaction and return to IDLE.
- `busy`  out  1  high from the cycle after acceptance until `data_valid`.
- `data`  out  8  last byte read; held until the next `data_valid`.
- `data_valid`  out  1  one-cycle pulse, byte available on `data`.
- `sclk`  out  1  flash clock, clk/2.
- `select`  out  1  flash chip select, active low.
- `io_out`  out  4  nibble driven to flash, IO3..IO0.
- `io_oe`  out  4  per-line output enable.
- `io_in`  in  4  nibble returned by flash.

## Operation
- States: IDLE, CMD, ADDR, MODE, DUMMY, DATA, STREAM, GAP.
- Each sclk period is two clk cycles. Phase 0: `sclk`=0 and outputs update. Phase 1: `sclk`=1. `io_in` is sampled on the clk edge that ends phase 1.
- IDLE: `select`=1, `sclk`=0, `io_oe`=0. An accepted `rd_req` latches `addr` and enters CMD.
- CMD: 8 sclk periods. `io_oe`=4'b0001. `io_out[0]` carries `CMD` bits 7..0. `io_out[3:1]`=0.
- ADDR: 6 sclk periods. `io_oe`=4'hF. Sends address nibbles [23:20] first, down to [3:0].
- MODE: 2 sclk periods. `io_oe`=4'hF. Sends `MODE` high nibble, then low nibble.
- DUMMY: `DUMMY_CYCLES` sclk periods. `io_oe`=0.
- DATA: 2 sclk periods, `io_oe`=0. The first nibble sampled is data[7:4], the second is data[3:0]. Then `data_valid` pulses, `busy` falls, and the state becomes STREAM with `select` held low and `sclk`=0.
- STREAM:
  - `rd_req` with `addr` == last address+1 (24-bit wrap, FFFFFF→000000 counts as sequential) goes straight to DATA.
  - Any other address enters GAP.
- GAP: `select`=1 for 2 clk, then CMD with the new address.
- `restart` in any state: next cycle is IDLE, `select`=1, `sclk`=0, `io_oe`=0, and `busy`=0. No `data_valid` is issued for the aborted transaction. `restart` takes priority over a coincident `rd_req`.
- `rd_req` while `busy`=1 is ignored.
- Reset values: `select`=1, `sclk`=0, `io_out`=0, `io_oe`=0, `busy`=0, `data_valid`=0, `data`=8'h00. State becomes IDLE and the stream address is invalidated, so the first read after reset is never treated as sequential.

## Timing
- `rd_req` accepted at edge T. From T+1: `busy`=1, `select`=0, CMD phase 0.
- Random read, default parameters: 20 sclk = 40 clk of command, address, mode and dummy, plus 4 clk of data. `data_valid`=1 in cycle T+45.
- Sequential read from STREAM: `data_valid` in cycle T+5.
- Non-sequential read from STREAM: 2 clk GAP, then a full transaction. `data_valid` in cycle T+47.
- A new `rd_req` is accepted in the same cycle `data_valid` is high: `busy` is already 0 in that cycle.
- `select` never toggles while `sclk`=1.

## Test plan
- Reset, then read 0x000123 with the emulator holding byte 0xA5 → CMD bits on IO0 are 1110_1011, address nibbles are 0,0,0,1,2,3, `data`=0xA5 with `data_valid` at T+45.
- Reads of 0x10, 0x11, 0x12 back-to-back → `select` stays low throughout, 2nd and 3rd `data_valid` each arrive 5 cycles after acceptance, and the bytes match the emulator.
- Read 0x10, then 0x40 → `select` goes high for exactly 2 clk, full command re-issued, `data_valid` at T+47.
- Read 0xFFFFFF, then 0x000000 → second read is streamed (latency 5).
- `restart` asserted during ADDR → next cycle `select`=1, `busy`=0, and no `data_valid`. A following read of 0x200 completes with 45-cycle latency.
- `rd_req` held high while `busy` → only one transaction. `reset` asserted mid-DATA → all outputs at their reset values the next cycle.
